// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_pkg
// Description : Shared constants for the UART receive/transmit FIFOs: default
//               character and address widths, plus the drain FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

    // Default character width (matches uart_core rx_data) and FIFO address width
    localparam int C_DATA_W = 8;
    localparam int C_ADDR_W = 4;

    // Drain FSM state type and encodings
    typedef logic [0:0] drain_state_t;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_ACK  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Bundles the core-side RX handshake, the register-file
//               valid/ready read port and the status/control signals of the
//               receive FIFO.
//   slave  : the FIFO itself (consumes control, produces data/status)
//   master : the surrounding logic (core + register file)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W
) ();

    logic              rst_soft;      // soft reset from SOFTRESET
    logic              en;            // drain enable from RXEN
    logic              core_rx_ready; // core holds a received byte
    logic [DATA_W-1:0] core_rx_data;  // byte from the core
    logic              core_read_en;  // acknowledge pulse to the core
    logic [DATA_W-1:0] rdata;         // head-of-FIFO byte (0 when empty)
    logic              rvalid;        // FIFO not empty
    logic              rready;        // consumer pop request
    logic [ADDR_W:0]   level;         // occupancy 0..2**ADDR_W
    logic [ADDR_W:0]   thresh_level;  // level threshold, 0 disables
    logic              thresh;        // level >= thresh_level
    logic              overrun;       // sticky dropped-byte flag
    logic              clr_overrun;   // clears overrun

    modport slave (
        input  rst_soft, en, core_rx_ready, core_rx_data, rready,
               thresh_level, clr_overrun,
        output core_read_en, rdata, rvalid, level, thresh, overrun
    );

    modport master (
        output rst_soft, en, core_rx_ready, core_rx_data, rready,
               thresh_level, clr_overrun,
        input  core_read_en, rdata, rvalid, level, thresh, overrun
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Simple dual-port register array, 2**ADDR_W x DATA_W.
//               Synchronous write, asynchronous read (first-word-fall-through).
// Ports       : clk     - system clock
//               wr_en   - write strobe
//               wr_addr - write address
//               wr_data - write data
//               rd_addr - read address
//               rd_data - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [DATA_W-1:0] rd_data
);

    localparam int C_DEPTH = 1 << ADDR_W;

    // Storage is not reset: empty entries are never presented downstream
    logic [DATA_W-1:0] r_mem [C_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side buffer behind uart_core. A two-state drain FSM
//               acknowledges each received byte and pushes it into a FIFO;
//               the register file reads it through a valid/ready port.
// Ports       : clk_i - system clock
//               rst_i - synchronous active-high reset
//               bus   - uart_rx_fifo_if.slave (core handshake, read port,
//                       level/threshold/overrun status, soft reset, enable)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    uart_rx_fifo_if.slave   bus
);

    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    drain_state_t      r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overrun;

    logic              w_rst;
    logic              w_empty;
    logic              w_full;
    logic              w_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_rst   = rst_i | bus.rst_soft;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == C_DEPTH);

    // Capture request; gated by reset so no acknowledge escapes in a reset cycle
    assign w_req  = !w_rst && (r_state == C_ST_IDLE) && bus.en && bus.core_rx_ready;
    assign w_pop  = !w_empty && bus.rready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept
    assign w_push = w_req && (!w_full || w_pop);
    assign w_drop = w_req && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state   <= C_ST_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            // ACK lasts one cycle so the core has time to drop rx_ready
            r_state <= w_req ? C_ST_ACK : C_ST_IDLE;

            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase

            // A drop in the same cycle as a clear leaves the flag set
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (w_push),
        .wr_addr (r_wptr),
        .wr_data (bus.core_rx_data),
        .rd_addr (r_rptr),
        .rd_data (w_mem_rdata)
    );

    assign bus.core_read_en = w_req;
    assign bus.rvalid       = !w_empty;
    assign bus.rdata        = w_empty ? '0 : w_mem_rdata;
    assign bus.level        = r_level;
    assign bus.thresh       = (bus.thresh_level != '0) && (r_level >= bus.thresh_level);
    assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of uart_core.
- Drains each received byte from the core's RX handshake (rx_ready/data_read_en) into an on-chip FIFO, so the CPU can fall behind by up to DEPTH bytes without losing characters.
- Presents bytes to the register file through a valid/ready port, with fill level, threshold and sticky-overrun status.

Parameters:
- DATA_W, 8, character width; must match uart_core rx_data width.
- ADDR_W, 4, FIFO depth is 2**ADDR_W entries (16 by default); legal range 1..10.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rst_soft_i  in  1  soft reset, same effect as rst_i, taken from the SOFTRESET register.
- en_i  in  1  drain enable, taken from RXEN; when low, the core is never acknowledged.
- core_rx_ready_i  in  1  uart_core holds a received byte.
- core_rx_data_i  in  DATA_W  byte from uart_core; valid while core_rx_ready_i is high.
- core_read_en_o  out  1  one-cycle acknowledge pulse to uart_core data_read_en_i.
- rdata_o  out  DATA_W  head-of-FIFO byte; first-word-fall-through.
- rvalid_o  out  1  FIFO not empty.
- rready_i  in  1  consumer pops the head when rvalid_o and rready_i are both high.
- level_o  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- thresh_i  in  ADDR_W+1  level threshold.
- thresh_o  out  1  high when level_o >= thresh_i and thresh_i != 0.
- overrun_o  out  1  sticky; set when a byte is dropped because the FIFO is full.
- clr_overrun_i  in  1  clears overrun_o.

Behaviour:
- Reset (rst_i or rst_soft_i, synchronous):
  - all outputs go to 0: core_read_en_o, rvalid_o, level_o, thresh_o, overrun_o; rdata_o is 0 (read data is forced to 0 when empty).
  - Pointers are cleared and the FSM goes to IDLE.
  - Reset mid-transfer discards the FIFO contents and any in-flight acknowledge.
- Drain FSM, two states:
  - IDLE: if en_i and core_rx_ready_i, then: pulse core_read_en_o for exactly 1 cycle; push core_rx_data_i (accepted or dropped, see below); go to ACK. Otherwise stay in IDLE.
  - ACK: core_rx_ready_i is ignored for this one cycle, giving the core time to deassert and preventing a double capture; always return to IDLE.
  - Maximum drain rate is therefore 1 byte per 2 cycles, far faster than any line rate.
- Push acceptance: the push is accepted when the FIFO is not full, or when a pop happens in the same cycle. Otherwise the byte is dropped, overrun_o is set, and the core is still acknowledged so it can receive fresh data.
- Pop: occurs when rvalid_o and rready_i are high. rdata_o advances to the next entry in the cycle after the pop edge; with no pending entry, rvalid_o drops.
- Latency: a byte pushed at edge N shows rvalid_o=1 and rdata_o valid after edge N; level_o increments on the same edge.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - pop while empty: impossible, since rvalid_o=0.
  - rready_i asserted while empty has no effect.
- Pointers are ADDR_W bits wide and wrap modulo 2**ADDR_W. Full is level == 2**ADDR_W; empty is level == 0.
- Overrun priority: if clr_overrun_i and a set event occur in the same cycle, the set wins and overrun_o=1. A dropped byte leaves level_o unchanged.
- Threshold: thresh_o is combinational from the registered level_o; thresh_i == 0 disables it.
- en_i deasserted while in ACK: the FSM still returns to IDLE. In IDLE with en_i low, the core's byte stays in the core, which may flag its own overrun.

Decomposition:
- Shared header holds: default DATA_W/ADDR_W constants and the FSM state encodings (IDLE=0, ACK=1), so the TX-side FIFO can reuse them.
- One sub-module, uart_fifo_mem:
  - simple dual-port register array, 2**ADDR_W x DATA_W;
  - synchronous write port;
  - asynchronous read at the read pointer, needed for first-word-fall-through.
- Pointer, level, FSM and status logic live in uart_rx_fifo.

Test Plan:
- Reset and basic transfer:
  - Stimulus: reset; core presents 0xA5 with rx_ready=1 and drops rx_ready the cycle after the acknowledge.
  - Expected: exactly one core_read_en_o pulse; the next cycle shows rvalid_o=1, rdata_o=0xA5, level_o=1.
- In-order drain:
  - Stimulus: push 0x01..0x10 (16 bytes, ADDR_W=4) with rready_i=0; then hold rready_i=1.
  - Expected: level_o reaches 16, overrun_o=0; bytes pop out 0x01..0x10 in order; level_o returns to 0 and rvalid_o=0.
- Overrun and clear:
  - Stimulus: fill to 16, then present 0x77; later assert clr_overrun_i alone.
  - Expected on 0x77: core_read_en_o pulses, 0x77 is dropped, overrun_o=1 and stays high, level_o stays 16. On clr_overrun_i: overrun_o=0.
- Push and pop while full:
  - Stimulus: with level 16, the core byte 0x55 arrives in the same cycle as rready_i=1.
  - Expected: level_o stays 16, no overrun; 0x55 emerges as the 16th subsequent byte.
- Wrap-around and threshold:
  - Stimulus: push/pop interleaved 40 bytes, so the pointers wrap twice; thresh_i=4.
  - Expected: data order preserved; thresh_o=1 exactly while level_o >= 4.
- Soft reset mid-operation:
  - Stimulus: with level 5 and the FSM in ACK, assert rst_soft_i for 1 cycle.
  - Expected: next cycle level_o=0, rvalid_o=0, overrun_o=0, core_read_en_o=0; the next core byte is accepted normally.
